// File: rtl/cnn_cfg_pkg.sv
// Shared definitions for the Benes input-configuration loader: default sizes,
// controller state encoding and the lane-count clamp.
package cnn_cfg_pkg;

  localparam int N_DEF     = 32;
  localparam int I_DEF     = 32;
  localparam int SW_DEF    = 10;
  localparam int DAW_DEF   = 16;
  localparam int CAW_DEF   = 5;
  localparam int STEPS_DEF = 32;
  localparam int LANE_W    = N_DEF;
  localparam int NV_W      = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FETCH,
    PRESENT,
    FIN
  } state_t;

  // Requested lane counts above the physical lane count load every lane.
  function automatic logic [NV_W-1:0] clamp_lanes(input logic [NV_W-1:0] n, input int lanes);
    return (int'(n) > lanes) ? NV_W'(lanes) : n;
  endfunction

endpackage

// File: rtl/lane_bank.sv
// LANES x WIDTH register file: synchronous clear-all, one write port, and every
// lane exposed side by side on a flat bus (lane k at bits [k*WIDTH +: WIDTH]).
module lane_bank
  import cnn_cfg_pkg::*;
#(
  parameter int LANES = I_DEF,
  parameter int WIDTH = LANE_W,
  localparam int AW   = $clog2(LANES)
) (
  input  logic                   clk_sig,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [LANES*WIDTH-1:0] o_bus
);

  logic [WIDTH-1:0] r_lane [LANES];

  // NOTE: the bank is flops read in parallel, not a RAM macro, so it can and must reset to 0.
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) r_lane[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (i_clr)                            r_lane[k] <= '0;
        else if (i_we && i_waddr == AW'(k))   r_lane[k] <= i_wdata;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bus
    assign o_bus[g*WIDTH +: WIDTH] = r_lane[g];
  end

endmodule

// File: rtl/benes_config_loader.sv
// Loads one input vector into the lane bank, then streams STEPS switch-control
// words to the Benes stage over a valid/ready handshake.
module benes_config_loader
  import cnn_cfg_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int I     = I_DEF,
  parameter int SW    = SW_DEF,
  parameter int DAW   = DAW_DEF,
  parameter int CAW   = CAW_DEF,
  parameter int STEPS = STEPS_DEF
) (
  input  logic             clk_sig,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DAW-1:0]   base_addr,
  input  logic [NV_W-1:0]  n_valid,
  output logic             data_rd_en,
  output logic [DAW-1:0]   data_addr,
  input  logic [N-1:0]     data_rdata,
  output logic             cfg_rd_en,
  output logic [CAW-1:0]   cfg_addr,
  input  logic [SW-1:0]    cfg_rdata,
  output logic [I*N-1:0]   xin_bus,
  output logic [SW-1:0]    s_sig,
  output logic             configure,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             busy,
  output logic             done
);

  localparam int LAW = $clog2(I);
  localparam logic [CAW:0] LAST_STEP = (CAW+1)'(STEPS - 1);

  state_t            r_state, w_next;
  logic [DAW-1:0]    r_base;
  logic [NV_W-1:0]   r_n_eff, r_rd_cnt, r_wr_cnt, w_n_clamp;
  logic              r_rd_pend, r_cfg_pend;
  logic [CAW:0]      r_step_cnt, w_step_inc;
  logic [SW-1:0]     r_s;
  logic              w_start_ok, w_xfer;

  assign w_n_clamp  = clamp_lanes(n_valid, I);
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_xfer     = (r_state == PRESENT) && step_ready;
  assign w_step_inc = r_step_cnt + 1'b1;

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FIN);
  assign step_valid = (r_state == PRESENT);
  assign configure  = (r_state == FETCH) || (r_state == PRESENT);
  assign s_sig      = r_s;

  // The next control word is requested in the same cycle the current one is
  // accepted, so an unstalled step costs two cycles instead of three.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_next     = r_state;
    data_rd_en = 1'b0;
    data_addr  = '0;
    cfg_rd_en  = 1'b0;
    cfg_addr   = '0;
    unique case (r_state)
      IDLE: if (start) w_next = (w_n_clamp == '0) ? FETCH : LOAD;
      LOAD: begin
        data_rd_en = 1'b1;
        data_addr  = r_base + DAW'(r_rd_cnt);
        if (r_rd_cnt == r_n_eff - 1'b1) w_next = DRAIN;
      end
      DRAIN: w_next = FETCH;
      FETCH: begin
        if (!r_cfg_pend) begin
          cfg_rd_en = 1'b1;
          cfg_addr  = r_step_cnt[CAW-1:0];
        end else begin
          w_next = PRESENT;
        end
      end
      PRESENT: begin
        if (step_ready) begin
          if (r_step_cnt == LAST_STEP) begin
            w_next = FIN;
          end else begin
            cfg_rd_en = 1'b1;
            cfg_addr  = w_step_inc[CAW-1:0];
            w_next    = FETCH;
          end
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_n_eff    <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_rd_pend  <= 1'b0;
      r_cfg_pend <= 1'b0;
      r_step_cnt <= '0;
      r_s        <= '0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= data_rd_en;
      if (w_start_ok) begin
        r_base     <= base_addr;
        r_n_eff    <= w_n_clamp;
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
        r_step_cnt <= '0;
      end
      if (data_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (r_rd_pend)  r_wr_cnt <= r_wr_cnt + 1'b1;
      if (cfg_rd_en) begin
        r_cfg_pend <= 1'b1;
      end else if (r_state == FETCH && r_cfg_pend) begin
        r_s        <= cfg_rdata;
        r_cfg_pend <= 1'b0;
      end
      if (w_xfer) r_step_cnt <= w_step_inc;
    end
  end

  lane_bank #(
    .LANES (I),
    .WIDTH (N)
  ) u_lane_bank (
    .clk_sig (clk_sig),
    .rst_n   (rst_n),
    .i_clr   (w_start_ok),
    .i_we    (r_rd_pend),
    .i_waddr (r_wr_cnt[LAW-1:0]),
    .i_wdata (data_rdata),
    .o_bus   (xin_bus)
  );

endmodule

// File: tb/tb_benes_config_loader.sv
// Self-checking bench for benes_config_loader: behavioural data/config RAMs,
// expected addresses and control words queued at start, compared as they appear.
module tb_benes_config_loader;
  import cnn_cfg_pkg::*;

  localparam int N = 32, I = 32, SW = 10, DAW = 16, CAW = 5, STEPS = 32;

  logic             clk_sig = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [DAW-1:0]   base_addr = '0;
  logic [5:0]       n_valid = '0;
  logic             data_rd_en;
  logic [DAW-1:0]   data_addr;
  logic [N-1:0]     data_rdata = '0;
  logic             cfg_rd_en;
  logic [CAW-1:0]   cfg_addr;
  logic [SW-1:0]    cfg_rdata = '0;
  logic [I*N-1:0]   xin_bus;
  logic [SW-1:0]    s_sig;
  logic             configure, step_valid, busy, done;
  logic             step_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [SW-1:0]  exp_q[$];
  logic [DAW-1:0] addr_q[$];

  always #5 clk_sig = ~clk_sig;

  benes_config_loader dut (
    .clk_sig(clk_sig), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .n_valid(n_valid), .data_rd_en(data_rd_en), .data_addr(data_addr),
    .data_rdata(data_rdata), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_rdata(cfg_rdata), .xin_bus(xin_bus), .s_sig(s_sig),
    .configure(configure), .step_valid(step_valid), .step_ready(step_ready),
    .busy(busy), .done(done)
  );

  function automatic logic [SW-1:0] cfg_word(input logic [CAW-1:0] a);
    return {a, ~a} ^ 10'h0C3;
  endfunction

  function automatic logic [N-1:0] data_word(input logic [DAW-1:0] a);
    return 32'hA000 + 32'(a);
  endfunction

  // Synchronous RAM models: data is on the bus the cycle after the strobe.
  always @(posedge clk_sig) begin
    if (data_rd_en) data_rdata <= data_word(data_addr);
    if (cfg_rd_en)  cfg_rdata  <= cfg_word(cfg_addr);
  end

  // One complete job. bp_step/bp_len stall one step; rst_step pulls reset when
  // that step is presented; busy_start pulses start again during LOAD.
  task automatic run_job(input string tag, input logic [DAW-1:0] base, input logic [5:0] nv,
                         input int bp_step, input int bp_len, input bit busy_start,
                         input int rst_step);
    int n_eff, first_exp, done_exp, first_valid, n_reads, n_xfers, held;
    bit finished;
    logic [I*N-1:0] exp_bus;
    n_eff = (int'(nv) > I) ? I : int'(nv);
    exp_bus = '0;
    addr_q.delete();
    exp_q.delete();
    for (int k = 0; k < n_eff; k++) begin
      addr_q.push_back(base + DAW'(k));
      exp_bus[k*N +: N] = data_word(base + DAW'(k));
    end
    for (int k = 0; k < STEPS; k++) exp_q.push_back(cfg_word(CAW'(k)));
    first_exp = (n_eff == 0) ? 3 : n_eff + 4;
    done_exp  = first_exp + 2*(STEPS-1) + 1 + ((bp_step >= 0) ? bp_len : 0);
    first_valid = -1; n_reads = 0; n_xfers = 0; held = 0; finished = 1'b0;

    @(negedge clk_sig);
    base_addr = base; n_valid = nv; start = 1'b1;
    @(negedge clk_sig);
    start = 1'b0;
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      if (data_rd_en) begin
        checks++;
        if (addr_q.size() == 0 || data_addr !== addr_q[0] || cyc != n_reads + 1) begin
          errors++;
          $display("FAIL %s data_addr cyc %0d got %h want %h (read %0d)", tag, cyc, data_addr,
                   (addr_q.size() != 0) ? addr_q[0] : 16'hxxxx, n_reads);
        end
        if (addr_q.size() != 0) void'(addr_q.pop_front());
        n_reads++;
      end
      if (busy_start && cyc == 3) begin
        start = 1'b1; base_addr = 16'h5555; n_valid = 6'd5;
      end else begin
        start = 1'b0;
      end
      if (step_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          checks++;
          if (cyc != first_exp) begin
            errors++;
            $display("FAIL %s first step_valid cyc got %0d want %0d", tag, cyc, first_exp);
          end
        end
        if (n_xfers == rst_step) begin
          rst_n = 1'b0; step_ready = 1'b0;
          #1;
          checks++;
          if ({data_rd_en, data_addr, cfg_rd_en, cfg_addr, s_sig, configure, step_valid, busy, done} !== '0
              || xin_bus !== '0) begin
            errors++;
            $display("FAIL %s async reset outputs busy=%b valid=%b cfg=%b s=%h", tag, busy, step_valid,
                     configure, s_sig);
          end
          repeat (3) begin
            @(negedge clk_sig);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
              errors++;
              $display("FAIL %s held reset done=%b busy=%b want 0 0", tag, done, busy);
            end
          end
          rst_n = 1'b1; step_ready = 1'b1;
          return;
        end
        checks++;
        if (exp_q.size() == 0 || s_sig !== exp_q[0] || xin_bus !== exp_bus) begin
          errors++;
          $display("FAIL %s step %0d s_sig got %h want %h xin_ok=%b", tag, n_xfers, s_sig,
                   (exp_q.size() != 0) ? exp_q[0] : 10'hxxx, xin_bus === exp_bus);
        end
        if (n_xfers == bp_step && held < bp_len) begin
          step_ready = 1'b0;
          held++;
        end else begin
          step_ready = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_xfers++;
        end
      end else begin
        step_ready = 1'b1;  // ready without valid must not count as a transfer
      end
      #1;
      if (cfg_rd_en) begin
        checks++;
        if (cfg_addr !== CAW'(n_xfers)) begin
          errors++;
          $display("FAIL %s cfg_addr cyc %0d got %0d want %0d", tag, cyc, cfg_addr, n_xfers);
        end
      end
      if (done) begin
        checks++;
        if (cyc != done_exp || n_xfers != STEPS) begin
          errors++;
          $display("FAIL %s done cyc got %0d want %0d xfers %0d", tag, cyc, done_exp, n_xfers);
        end
        finished = 1'b1;
      end
      if (!finished) @(negedge clk_sig);
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout waiting for done (xfers %0d)", tag, n_xfers);
      return;
    end
    @(negedge clk_sig);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || configure !== 1'b0) begin
      errors++;
      $display("FAIL %s after done got done=%b busy=%b cfg=%b want 0 0 0", tag, done, busy, configure);
    end
    checks++;
    if (n_reads != n_eff || xin_bus !== exp_bus || s_sig !== cfg_word(CAW'(STEPS-1))) begin
      errors++;
      $display("FAIL %s final reads got %0d want %0d xin_ok=%b s_sig=%h", tag, n_reads, n_eff,
               xin_bus === exp_bus, s_sig);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_rd_en, cfg_rd_en, s_sig, configure, step_valid, busy, done} !== '0 || xin_bus !== '0) begin
      errors++;
      $display("FAIL reset outputs busy=%b valid=%b s=%h", busy, step_valid, s_sig);
    end
    repeat (2) @(negedge clk_sig);
    rst_n = 1'b1;
    @(negedge clk_sig);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle after reset busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_full_load();
    run_job("full", 16'h0010, 6'd32, -1, 0, 1'b0, -1);
  endtask

  task automatic test_partial_load();
    run_job("partial3", 16'h0100, 6'd3, -1, 0, 1'b0, -1);
    run_job("clamp40_wrap", 16'hFFF0, 6'd40, -1, 0, 1'b0, -1);
  endtask

  task automatic test_zero_lanes();
    run_job("zero", 16'h0200, 6'd0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_job("backpressure", 16'h0030, 6'd8, 7, 5, 1'b0, -1);
  endtask

  task automatic test_start_while_busy();
    run_job("busy_start", 16'h0400, 6'd10, -1, 0, 1'b1, -1);
  endtask

  task automatic test_async_reset();
    run_job("reset_mid", 16'h0010, 6'd32, -1, 0, 1'b0, 12);
    run_job("after_reset", 16'h0010, 6'd32, -1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_partial_load();
    test_zero_lanes();
    test_backpressure();
    test_start_while_busy();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
